seg7_scan_driver: RTL and testbench

Time-multiplexed N-digit seven-segment display driver for the microwave front panel. It replaces the per-digit combinational decoding of the minute/second digits with one shared segment bus and a one-hot digit-enable bus. A refresh prescaler scans the digits in turn. Digit values are double-buffered so a display update never tears mid-frame. It sits between the countdown timer (BCD digit source) and the panel pins.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_encode.sv | 19 +
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment bus type, segment bit positions and hex glyph table.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0-9 then A, b, C, d, E, F.
    localparam logic [6:0] SEG_ENC [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - 4-bit value plus blank and dp to active-high segment bus.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_blank,
    input  logic       i_dp,
    output seg_t       o_seg
);

    always_comb begin
        o_seg         = '0;
        o_seg[SEG_DP] = i_dp;
        if (!i_blank) begin
            o_seg[SEG_G:SEG_A] = SEG_ENC[i_val];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment scanner with double-buffered digits.
// Optional SEG7_BLINK_EN adds blink_mask, BLINK_FRAMES and a frame-based blink phase.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 0
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PC_W-1:0]       PC_LAST  = PC_W'(REFRESH_DIV - 1);
    localparam seg_t                  SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW != 0}};

    logic [PC_W-1:0]         r_pc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_wrap_d;

    logic                    w_pc_tc;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_zero_run;
    logic [3:0]              w_sel_val;
    logic                    w_sel_blank;
    logic                    w_sel_dp;
    logic                    w_blink_off;
    seg_t                    w_enc_seg;
    seg_t                    w_seg_next;

    assign w_pc_tc = (r_pc == PC_LAST);
    assign w_wrap  = w_pc_tc && (r_idx == IDX_LAST);

    always_comb begin
        w_an_next = '0;
        w_sel_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_next[i] = (r_idx == IDX_W'(i));
            if (w_an_next[i]) begin
                w_sel_val = r_disp[4*i +: 4];
            end
        end
    end

    // Walk down from the top digit; a digit is blankable while all digits above it and itself are zero.
    always_comb begin
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run   = w_zero_run & (r_disp[4*i +: 4] == 4'd0);
            w_lz_mask[i] = blank_lz & w_zero_run;
        end
    end

    assign w_sel_blank = |(w_lz_mask & w_an_next);
    assign w_sel_dp    = |(dp_mask & w_an_next);

    seg7_encode u_encode (
        .i_val   (w_sel_val),
        .i_blank (w_sel_blank),
        .i_dp    (w_sel_dp),
        .o_seg   (w_enc_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BL_W'(1);
            end
        end
    end

    assign w_blink_off = r_blink_phase & (|(blink_mask & w_an_next));
`else
    assign w_blink_off = 1'b0;
`endif

    assign w_seg_next = w_blink_off ? 8'h00 : w_enc_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_idx      <= '0;
            r_pend     <= '0;
            r_disp     <= '0;
            r_wrap_d   <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            r_pc <= w_pc_tc ? '0 : r_pc + PC_W'(1);
            if (w_pc_tc) begin
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end
            if (load) begin
                r_pend <= digits;
            end
            // A load landing on the wrap cycle bypasses pending so it is not delayed a frame.
            if (w_wrap) begin
                r_disp <= load ? digits : r_pend;
            end
            r_wrap_d   <= w_wrap;
            seg        <= w_seg_next ^ SEG_OFF;
            an         <= w_an_next ^ AN_OFF;
            frame_done <= r_wrap_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against an arithmetic frame model.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int AL = 0;
    localparam int NR = N * R;
`ifdef SEG7_BLINK_EN
    localparam int BF = 2;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load = 1'b0;
    logic           blank_lz = 1'b0;
    logic [4*N-1:0] digits = '0;
    logic [N-1:0]   dp_mask = '0;
    logic [N-1:0]   blink_mask = '0;
    logic [7:0]     seg;
    logic [N-1:0]   an;
    logic           frame_done;

    int n_checks = 0;
    int n_fail = 0;

    int          cyc = 0;
    int          out_cyc = 0;
    int          load_cyc[$];
    logic [15:0] load_val[$];
    logic [7:0]  exp_seg;
    logic [N-1:0] exp_an;
    logic        exp_fd;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
`ifdef SEG7_BLINK_EN
        .BLINK_FRAMES(BF),
`endif
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
`ifdef SEG7_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Value on display during frame f: the last load strictly before that frame began.
    function automatic logic [15:0] shown_in_frame(input int f);
        logic [15:0] v = 16'h0000;
        foreach (load_cyc[k]) if (load_cyc[k] < f * NR) v = load_val[k];
        return v;
    endfunction

    task automatic tick();
        int f, d;
        logic [15:0] v;
        logic [7:0] s;
        @(posedge clk);
        if (reset) begin
            exp_seg = (AL != 0) ? 8'hFF : 8'h00;
            exp_an  = (AL != 0) ? '1 : '0;
            exp_fd  = 1'b0;
            cyc     = 0;
            out_cyc = -1;
            load_cyc.delete();
            load_val.delete();
        end else begin
            f = cyc / NR;
            d = (cyc / R) % N;
            v = shown_in_frame(f);
            s[7] = dp_mask[d];
            s[6:0] = (blank_lz && d >= 1 && (v >> (4 * d)) == 16'h0) ? 7'h00 : glyph(v[4*d +: 4]);
`ifdef SEG7_BLINK_EN
            if (blink_mask[d] && ((f / BF) % 2 == 1)) s = 8'h00;
`endif
            exp_seg = (AL != 0) ? ~s : s;
            exp_an  = (AL != 0) ? ~(N'(1) << d) : (N'(1) << d);
            exp_fd  = (cyc % NR == 0) && (cyc > 0);
            if (load) begin
                load_cyc.push_back(cyc);
                load_val.push_back(digits);
            end
            out_cyc = cyc;
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (seg !== 8'h00 || an !== 4'b0000 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: seg=%h an=%b fd=%b expected seg=00 an=0000 fd=0", seg, an, frame_done);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (seg !== 8'h3F || an !== 4'b0001 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL first_output: seg=%h an=%b fd=%b expected seg=3F an=0001 fd=0", seg, an, frame_done);
        end
    endtask

    task automatic test_scan_zero();
        int last_fd = -1;
        for (int i = 0; i < 3 * NR; i++) begin
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL scan_zero c=%0d: seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                         out_cyc, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (frame_done) begin
                if (last_fd >= 0) begin
                    n_checks++;
                    if (out_cyc - last_fd !== NR) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d expected %0d", out_cyc - last_fd, NR);
                    end
                end
                last_fd = out_cyc;
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [7:0] got [N];
        logic [7:0] want [N] = '{8'h3F, 8'h4F, 8'h6F, 8'h3F};
        int fl;
        while (cyc % NR != 6) tick();
        fl = cyc / NR;
        digits = 16'h0930;
        load = 1'b1;
        tick();
        load = 1'b0;
        digits = 16'h8888;
        for (int i = 0; i < 2 * NR; i++) begin
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL load_midframe c=%0d: seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                         out_cyc, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (out_cyc / NR == fl + 1) got[(out_cyc / R) % N] = seg;
        end
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (got[k] !== want[k]) begin
                n_fail++;
                $display("FAIL load_0930_digit%0d: seg=%h expected %h", k, got[k], want[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        while (cyc % NR != NR - 1) tick();
        digits = 16'h4321;
        load = 1'b1;
        tick();
        digits = 16'h1111;
        tick();
        digits = 16'h2222;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3 * NR; i++) begin
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d: seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                         out_cyc, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [15:0] vals [4] = '{16'h0005, 16'h0050, 16'h0000, 16'h0100};
        blank_lz = 1'b1;
        foreach (vals[k]) begin
            digits = vals[k];
            load = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 2 * NR; i++) begin
                tick();
                n_checks++;
                if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                    n_fail++;
                    $display("FAIL blank_lz v=%h c=%0d: seg=%h an=%b expected seg=%h an=%b",
                             vals[k], out_cyc, seg, an, exp_seg, exp_an);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_hex_dp();
        dp_mask = 4'b0100;
        digits = 16'hFA00;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * NR; i++) begin
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL hex_dp c=%0d: seg=%h an=%b expected seg=%h an=%b",
                         out_cyc, seg, an, exp_seg, exp_an);
            end
        end
        dp_mask = '0;
    endtask

    task automatic test_reset_midframe();
        while (cyc % NR != 0) tick();
        digits = 16'h1234;
        load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc % NR != 2 * R + 1) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (seg !== 8'h00 || an !== 4'b0000 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midframe: seg=%h an=%b fd=%b expected seg=00 an=0000 fd=0", seg, an, frame_done);
        end
        reset = 1'b0;
        for (int i = 0; i < 2 * NR + 1; i++) begin
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL after_reset c=%0d: seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                         out_cyc, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 7) == 0) dp_mask = N'($urandom);
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL random c=%0d: seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                         out_cyc, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        load = 1'b0;
        blank_lz = 1'b0;
        dp_mask = '0;
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink();
        digits = 16'h0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        blink_mask = 4'b0001;
        for (int i = 0; i < 8 * NR; i++) begin
            tick();
            n_checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL blink c=%0d: seg=%h an=%b expected seg=%h an=%b",
                         out_cyc, seg, an, exp_seg, exp_an);
            end
        end
        blink_mask = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan_zero();
        test_load_midframe();
        test_back_to_back();
        test_blank_lz();
        test_hex_dp();
        test_reset_midframe();
        test_random();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
